// File: rtl/calc_pkg.sv
// Shared encodings for the stepwise calculator: state codes, opcodes, default width.
package calc_pkg;

  localparam int WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    GET_A  = 2'd0,
    GET_B  = 2'd1,
    GET_OP = 2'd2,
    SHOW   = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SLT = 3'b101
  } op_t;

endpackage

// File: rtl/ula_param.sv
// Combinational arithmetic/logic unit with carry, signed overflow, zero and
// invalid-opcode flags. Opcodes 110/111 yield zero result with op_err set.
module ula_param
  import calc_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] y,
  output logic             cout,
  output logic             overflow,
  output logic             zero,
  output logic             op_err
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;

  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  // Operation select; diff[WIDTH] is the borrow, so cout on SUB is its inverse.
  always_comb begin
    y        = '0;
    cout     = 1'b0;
    overflow = 1'b0;
    op_err   = 1'b0;
    case (op)
      OP_ADD: begin
        y        = sum[WIDTH-1:0];
        cout     = sum[WIDTH];
        overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        y        = diff[WIDTH-1:0];
        cout     = ~diff[WIDTH];
        overflow = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: y = a & b;
      OP_OR:  y = a | b;
      OP_XOR: y = a ^ b;
      OP_SLT: y = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default: op_err = 1'b1;
    endcase
  end

  // Zero flag derived from the selected result for every opcode.
  assign zero = (y == '0);

endmodule

// File: rtl/calculadora_param.sv
// Push-button stepped calculator: capture A, B, opcode on successive enter
// presses, then show the registered result and flags.
//
// state  | meaning
// GET_A  | waiting for operand A on data_in
// GET_B  | waiting for operand B on data_in
// GET_OP | waiting for opcode on data_in[2:0]; computes on capture
// SHOW   | result valid; enter returns to GET_A, or GET_B with chain
module calculadora_param
  import calc_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEFAULT,
  parameter int SYNC_ENTER = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enter,
  input  logic             chain,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  output logic             cout,
  output logic             overflow,
  output logic             zero,
  output logic             op_err,
  output logic [1:0]       state_out
);

  state_t           state_q, state_d;
  logic [1:0]       sync_q;
  logic [1:0]       fill_q;
  logic             enter_s;
  logic             enter_prev;
  logic             armed;
  logic             fill_done;
  logic             enter_pulse;
  logic [WIDTH-1:0] reg_a, reg_b, result_q;
  logic [2:0]       opcode_q;
  logic [2:0]       alu_op;
  logic [WIDTH-1:0] alu_y;
  logic             alu_cout, alu_ovf, alu_zero, alu_err;
  logic             cout_q, ovf_q, zero_q, err_q;

  // fill_done marks the synchroniser as holding real samples, so that the
  // reset-cleared zeros are not mistaken for a released button.
  assign enter_s     = (SYNC_ENTER != 0) ? sync_q[1] : enter;
  assign fill_done   = (SYNC_ENTER != 0) ? fill_q[1] : 1'b1;
  assign enter_pulse = armed & enter_s & ~enter_prev;

  // Synchroniser, edge detector and post-reset arming (enter must be seen low first).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q     <= '0;
      fill_q     <= '0;
      enter_prev <= 1'b0;
      armed      <= 1'b0;
    end else begin
      sync_q     <= {sync_q[0], enter};
      fill_q     <= {fill_q[0], 1'b1};
      enter_prev <= enter_s;
      armed      <= armed | (fill_done & ~enter_s);
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= GET_A;
    else          state_q <= state_d;
  end

  // Next-state logic; advances only on an enter pulse.
  always_comb begin
    state_d = state_q;
    if (enter_pulse) begin
      case (state_q)
        GET_A:   state_d = GET_B;
        GET_B:   state_d = GET_OP;
        GET_OP:  state_d = SHOW;
        SHOW:    state_d = chain ? GET_B : GET_A;
        default: state_d = GET_A;
      endcase
    end
  end

  // Live opcode during GET_OP so the ALU result is ready on the capture edge.
  assign alu_op = (state_q == GET_OP) ? data_in[2:0] : opcode_q;

  ula_param #(.WIDTH(WIDTH)) u_ula (
    .a        (reg_a),
    .b        (reg_b),
    .op       (alu_op),
    .y        (alu_y),
    .cout     (alu_cout),
    .overflow (alu_ovf),
    .zero     (alu_zero),
    .op_err   (alu_err)
  );

  // Operand/opcode capture and result/flag registration on enter pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      reg_a    <= '0;
      reg_b    <= '0;
      opcode_q <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b1;
      err_q    <= 1'b0;
    end else if (enter_pulse) begin
      case (state_q)
        GET_A: reg_a <= data_in;
        GET_B: reg_b <= data_in;
        GET_OP: begin
          opcode_q <= data_in[2:0];
          result_q <= alu_y;
          cout_q   <= alu_cout;
          ovf_q    <= alu_ovf;
          zero_q   <= alu_zero;
          err_q    <= alu_err;
        end
        SHOW: if (chain) reg_a <= result_q;
        default: ;
      endcase
    end
  end

  assign result       = result_q;
  assign cout         = cout_q;
  assign overflow     = ovf_q;
  assign zero         = zero_q;
  assign op_err       = err_q;
  assign result_valid = (state_q == SHOW);
  assign state_out    = state_q;

endmodule
